sll_multicycle: RTL and testbench
=================================

Name: sll_multicycle

Overview:
- Multi-cycle logical shift-left unit. It is the left-shift counterpart of the combinational arithmetic right shifter in the ALU datapath.
- Operand A is shifted left by B, zero-filling from the LSB. Shift amounts of N or more give zero.
- The shift is resolved as a log2 decomposition over SW clock cycles: stage shifts of 16, 8, 4, 2, 1 for the default configuration.
- Valid/ready handshakes on both sides let it sit between the register-read stage and the multi-cycle ALU writeback arbiter.

Parameters:
- N, 32, operand and result width; must equal 2**SW.
- SW, 5, shift-amount field width; also the number of SHIFT cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A and B are valid this cycle.
- in_ready  output  1  unit can accept an operation (high only in IDLE).
- A  input  N  operand to shift.
- B  input  N  shift amount (unsigned, full width).
- out_valid  output  1  Z holds a completed result (high only in DONE).
- out_ready  input  1  consumer accepts Z this cycle.
- Z  output  N  result register.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, Z=0, out_valid=0, stage counter=SW-1, captured shamt=0. in_ready=1 in the first cycle after rst deasserts.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- IDLE:
  - On in_valid && in_ready at an edge: Z <= (|B[N-1:SW]) ? 0 : A.
  - Capture shamt <= B[SW-1:0]; counter k <= SW-1; go to SHIFT.
  - Without in_valid, remain in IDLE with Z unchanged.
- SHIFT, each edge:
  - If shamt[k]: Z <= Z << (1<<k), zero fill; else Z holds.
  - If k==0, go to DONE; else k <= k-1.
  - Exactly SW edges are spent in SHIFT regardless of shamt value; no early exit.
- DONE:
  - Z held stable while out_valid=1 && out_ready=0.
  - On out_ready at an edge: go to IDLE, Z retains its last value.
- Latency: accept edge at t0 → out_valid=1 in the cycle after edge t0+SW, which is 5 cycles for the default.
- No same-cycle handoff. IDLE is re-entered for at least one cycle before the next accept, so minimum issue interval is SW+2 cycles.
- Inputs are sampled only at the accept edge. A and B changes afterwards have no effect.
- in_valid during SHIFT/DONE is ignored, and no operation is queued. The producer must hold in_valid until it sees in_ready.
- out_ready outside DONE is ignored.
- Out-of-range shift: any bit of B[N-1:SW] set gives result 0, including B=32 and B=0xFFFF_FFFF. Still SW SHIFT cycles, with the same latency as in-range shifts.
- Shift amount 0 gives Z=A after the full latency.
- Reset mid-operation (SHIFT or DONE): the operation is abandoned, all registers return to reset values next edge, and no out_valid is produced for it.
- rst has priority over all handshake events in the same cycle.

Test Plan:
- Basic shifts:
  - A=0x0000_0001, B=31, pulse in_valid, out_ready=1 → out_valid rises exactly 5 cycles after accept edge, Z=0x8000_0000, held for one cycle, then in_ready=1.
  - A=0x1234_5678, B=4 → Z=0x2345_6780.
  - A=0xDEAD_BEEF, B=0 → Z=0xDEAD_BEEF.
  - A=0xFFFF_FFFF, B=13 → Z=0xFFFF_E000.
- Out of range: A=0xFFFF_FFFF with B=32, B=0x0001_0003 and B=0xFFFF_FFFF → Z=0 each time. Same 5-cycle latency.
- Backpressure:
  - A=0x0000_00F0, B=8, out_ready=0 for 10 cycles → out_valid and Z=0x0000_F000 stable throughout.
  - in_valid pulses with new A/B during SHIFT/DONE are ignored.
  - out_ready=1 → IDLE next edge.
- Input isolation: change A/B every cycle after the accept edge → result reflects only the values captured at accept.
- Back-to-back issue: in_valid held high with a stream of 4 operations and out_ready=1 → accepts spaced exactly 7 cycles apart; results in order and correct.
- Reset mid-op:
  - Assert rst for 1 cycle during the 3rd SHIFT cycle → next cycle Z=0, out_valid=0, in_ready=1.
  - A new A=0x3, B=1 then gives Z=0x6 with normal latency.
  - rst asserted in DONE together with out_ready → reset wins, with no extra transition.

Source files
------------

// File: rtl/sll_multicycle.sv
// sll_multicycle: multi-cycle logical shift-left, one log2 stage per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, A, B (operand side);
//        out_valid/out_ready, Z (result side). Z is the working/result register.
module sll_multicycle #(
    parameter int N  = 32,
    parameter int SW = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Z
);

    localparam int KW = (SW > 1) ? $clog2(SW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  z_q, z_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] shamt_q, shamt_d;
    logic [N-1:0]  step;

    // Stage distance for the bit currently being resolved: 2**k.
    assign step = N'(1) << k_q;

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        k_d     = k_q;
        shamt_d = shamt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Any high bit beyond the shift field forces a zero result;
                    // the SHIFT stages then only move zeros.
                    z_d     = (|B[N-1:SW]) ? '0 : A;
                    shamt_d = B[SW-1:0];
                    k_d     = KW'(SW - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shamt_q[k_q]) begin
                    z_d = z_q << step;
                end
                if (k_q == '0) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            z_q     <= '0;
            k_q     <= KW'(SW - 1);
            shamt_q <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            k_q     <= k_d;
            shamt_q <= shamt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Z         = z_q;

endmodule

// File: tb/tb_sll_multicycle.sv
// tb_sll_multicycle: directed self-checking bench for sll_multicycle.
// Drives inputs #1 after each rising edge and samples outputs there too.
module tb_sll_multicycle;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Z;

    int checks = 0;
    int errors = 0;

    sll_multicycle #(.N(32), .SW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation with out_ready held high; optionally scramble
    // A/B every cycle after the accept edge.
    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag,
                      input bit scr);
        A = a;
        B = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, ":in_ready_pre"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, ":busy"}, 32'(in_ready), 32'd0);
        chk({tag, ":ov_t0"}, 32'(out_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            if (scr) begin
                A = $urandom;
                B = $urandom;
            end
            tick();
            chk({tag, ":ov_early"}, 32'(out_valid), 32'd0);
        end
        if (scr) begin
            A = $urandom;
            B = $urandom;
        end
        tick();
        chk({tag, ":ov"}, 32'(out_valid), 32'd1);
        chk({tag, ":z"}, Z, exp);
        tick();
        chk({tag, ":in_ready_post"}, 32'(in_ready), 32'd1);
        chk({tag, ":ov_post"}, 32'(out_valid), 32'd0);
        chk({tag, ":z_hold"}, Z, exp);
    endtask

    logic [31:0] sa [4];
    logic [31:0] sb [4];
    logic [31:0] sz [4];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset:z", Z, 32'h0);
        chk("reset:ov", 32'(out_valid), 32'd0);
        chk("reset:in_ready", 32'(in_ready), 32'd1);

        // Basic shifts
        op(32'h0000_0001, 32'd31, 32'h8000_0000, "b31", 1'b0);
        op(32'h1234_5678, 32'd4, 32'h2345_6780, "b4", 1'b0);
        op(32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, "b0", 1'b0);
        op(32'hFFFF_FFFF, 32'd13, 32'hFFFF_E000, "b13", 1'b0);

        // Out of range
        op(32'hFFFF_FFFF, 32'd32, 32'h0, "oor32", 1'b0);
        op(32'hFFFF_FFFF, 32'h0001_0003, 32'h0, "oor10003", 1'b0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, "oorffff", 1'b0);

        // Input isolation
        op(32'h1234_5678, 32'd4, 32'h2345_6780, "iso", 1'b1);

        // Backpressure, with stray in_valid pulses during SHIFT and DONE
        A         = 32'h0000_00F0;
        B         = 32'd8;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        A = 32'h0000_0001;
        B = 32'd1;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("bp:ov_rise", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 3 == 0);
            A = $urandom;
            B = $urandom;
            tick();
            chk("bp:ov_hold", 32'(out_valid), 32'd1);
            chk("bp:z_hold", Z, 32'h0000_F000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp:in_ready", 32'(in_ready), 32'd1);
        chk("bp:ov_drop", 32'(out_valid), 32'd0);
        chk("bp:z_keep", Z, 32'h0000_F000);

        // Back-to-back stream, in_valid held high
        sa[0] = 32'h0000_0001; sb[0] = 32'd1;  sz[0] = 32'h0000_0002;
        sa[1] = 32'h0F0F_0F0F; sb[1] = 32'd16; sz[1] = 32'h0F0F_0000;
        sa[2] = 32'hFFFF_FFFF; sb[2] = 32'd33; sz[2] = 32'h0000_0000;
        sa[3] = 32'h8000_0001; sb[3] = 32'd31; sz[3] = 32'h8000_0000;
        begin
            int j;
            int r;
            int cyc;
            int last;
            bit acc;
            j    = 0;
            r    = 0;
            cyc  = 0;
            last = 0;
            A         = sa[0];
            B         = sb[0];
            in_valid  = 1'b1;
            out_ready = 1'b1;
            while (r < 4 && cyc < 200) begin
                acc = in_ready && in_valid;
                tick();
                cyc++;
                if (acc) begin
                    if (j > 0) begin
                        chk("b2b:spacing", 32'(cyc - last), 32'd7);
                    end
                    last = cyc;
                    j++;
                    if (j < 4) begin
                        A = sa[j];
                        B = sb[j];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                if (out_valid) begin
                    chk("b2b:z", Z, sz[r]);
                    r++;
                end
            end
            chk("b2b:count", 32'(r), 32'd4);
            in_valid = 1'b0;
        end
        tick();

        // Reset during the third SHIFT cycle
        A         = 32'h0000_FFFF;
        B         = 32'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid:z", Z, 32'h0);
        chk("rstmid:ov", 32'(out_valid), 32'd0);
        chk("rstmid:in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstmid:no_ov", 32'(out_valid), 32'd0);
        end
        op(32'h0000_0003, 32'd1, 32'h0000_0006, "post_rst", 1'b0);

        // Reset in DONE together with out_ready
        A         = 32'h0000_0005;
        B         = 32'd2;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("rstdone:ov", 32'(out_valid), 32'd1);
        chk("rstdone:z", Z, 32'h0000_0014);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstdone:z0", Z, 32'h0);
        chk("rstdone:ov0", 32'(out_valid), 32'd0);
        chk("rstdone:in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rstdone:idle", 32'(in_ready), 32'd1);
        chk("rstdone:z_idle", Z, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
